// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_arith_pkg
//  Description : Shared definitions for the digit-serial adder/subtractor:
//                FSM state encoding, digit-counter width helper and the
//                parameter legality check used at elaboration.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

    // Two-state controller: waiting for a request, or stepping digits.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of a counter that must hold 0 .. n-1; never narrower than 1 bit
    // so a single-digit configuration still has a legal vector.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    // Legal configurations: at least two result bits, and the digit size
    // must tile the operand exactly so the last digit lands on the MSB.
    function automatic bit params_ok(input int width, input int digit);
        return (width >= 2) && (digit >= 1) && (digit <= width)
               && ((width % digit) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_digit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_digit_adder
//  Description : Combinational DIGIT-bit ripple-carry adder slice.
//  Ports       : a, b  - digit operands (DIGIT bits)
//                cin   - carry into bit 0
//                sum   - digit sum (DIGIT bits)
//                cout  - carry out of the digit MSB
//                cmsb  - carry into the digit MSB (for signed overflow)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    // The carry is walked through a loop-local variable instead of a carry
    // vector so the chain stays a single combinational evaluation.
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        cmsb  = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            cmsb   = carry;  // last iteration leaves the carry into the MSB
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub
//  Description : Digit-serial adder/subtractor. Operands are captured on a
//                start request, processed DIGIT bits per clock LSB-first,
//                and the result is presented with a one-cycle done pulse.
//  Ports       : clk      - rising-edge clock
//                reset    - synchronous active-high reset
//                start    - request, honoured only while idle
//                sub      - 0: A+B, 1: A-B (sampled with start)
//                data_a   - operand A (sampled with start)
//                data_b   - operand B (sampled with start)
//                busy     - operation in flight
//                done     - one-cycle completion pulse
//                result   - sum/difference, held until the next completion
//                cout     - carry out of MSB (subtract: 1 = no borrow)
//                overflow - two's-complement signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int              c_NDIG = WIDTH / DIGIT;
    localparam int              c_CW   = cnt_width(c_NDIG);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NDIG - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    generate
        if (!params_ok(WIDTH, DIGIT)) begin : g_param_check
            $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_done;

    logic [DIGIT-1:0] w_sum;
    logic             w_dcout;
    logic             w_dcmsb;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    serial_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (r_a[DIGIT-1:0]),
        .b    (r_b[DIGIT-1:0]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_dcout),
        .cmsb (w_dcmsb)
    );

    // New digit enters at the top of the accumulator; after all digits the
    // first (least significant) digit has been pushed down to bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_acc_full
            assign w_acc_next = w_sum;
        end else begin : g_acc_shift
            assign w_acc_next = {w_sum, r_acc[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign w_last = (r_cnt == c_LAST);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B here and
                        // seed the carry with the +1.
                        r_a     <= data_a;
                        r_b     <= sub ? ~data_b : data_b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_acc   <= w_acc_next;
                    r_carry <= w_dcout;
                    r_cnt   <= r_cnt + c_ONE;
                    if (w_last) begin
                        r_result <= w_acc_next;
                        r_cout   <= w_dcout;
                        r_ovf    <= w_dcmsb ^ w_dcout;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state == RUN);
    assign done     = r_done;
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_addsub
//  Description : Directed bench for serial_addsub. Three instances cover
//                WIDTH/DIGIT = 16/1, 16/4 and 8/2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

    logic        clk;
    logic        reset;
    logic        start0, start1, start2;
    logic        sub_in;
    logic [15:0] a_in, b_in;

    logic        busy0, done0, cout0, ovf0;
    logic [15:0] res0;
    logic        busy1, done1, cout1, ovf1;
    logic [15:0] res1;
    logic        busy2, done2, cout2, ovf2;
    logic [7:0]  res2;

    int n_pass  = 0;
    int n_total = 0;

    serial_addsub #(.WIDTH(16), .DIGIT(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .sub(sub_in),
        .data_a(a_in), .data_b(b_in), .busy(busy0), .done(done0),
        .result(res0), .cout(cout0), .overflow(ovf0)
    );

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .sub(sub_in),
        .data_a(a_in), .data_b(b_in), .busy(busy1), .done(done1),
        .result(res1), .cout(cout1), .overflow(ovf1)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .sub(sub_in),
        .data_a(a_in[7:0]), .data_b(b_in[7:0]), .busy(busy2), .done(done2),
        .result(res2), .cout(cout2), .overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] r;
        logic        c;
        logic        v;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    function automatic logic get_busy(input int w);
        case (w)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic [15:0] get_res(input int w);
        case (w)
            0:       return res0;
            1:       return res1;
            default: return {8'h00, res2};
        endcase
    endfunction

    function automatic logic get_cout(input int w);
        case (w)
            0:       return cout0;
            1:       return cout1;
            default: return cout2;
        endcase
    endfunction

    function automatic logic get_ovf(input int w);
        case (w)
            0:       return ovf0;
            1:       return ovf1;
            default: return ovf2;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the
    // accepting rising edge, with operand inputs scrambled.
    task automatic launch(input int w, input logic [15:0] a,
                          input logic [15:0] b, input logic s);
        a_in   = a;
        b_in   = b;
        sub_in = s;
        start0 = (w == 0);
        start1 = (w == 1);
        start2 = (w == 2);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        a_in   = 16'($urandom);
        b_in   = 16'($urandom);
        sub_in = 1'($urandom);
    endtask

    // Waits (bounded) for done; lat = cycles after the accepting edge,
    // busy_n = falling edges with busy high. A start pulse with different
    // operands is injected on instance 0 at cycle glitch_at (0 = none).
    task automatic wait_done(input int w, input int glitch_at,
                             output int lat, output int busy_n);
        lat    = -1;
        busy_n = get_busy(w) ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (get_done(w)) begin
                lat = k;
                break;
            end
            if (get_busy(w)) busy_n++;
            if (k == glitch_at) begin
                start0 = 1'b1;
                a_in   = 16'hFFFF;
                b_in   = 16'hFFFF;
                sub_in = 1'b1;
            end else begin
                start0 = 1'b0;
            end
        end
        start0 = 1'b0;
    endtask

    initial begin
        int lat, busy_n, n_done;

        //          dut  a         b         s     r         c     v     lat
        vecs[0]  = '{0, 16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0, 16};
        vecs[1]  = '{0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16};
        vecs[2]  = '{0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 16};
        vecs[3]  = '{0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16};
        vecs[4]  = '{0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 16};
        vecs[5]  = '{0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16};
        vecs[6]  = '{0, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 16};
        vecs[7]  = '{0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 16};
        vecs[8]  = '{0, 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 16};
        vecs[9]  = '{1, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0, 4};
        vecs[10] = '{1, 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0, 4};
        vecs[11] = '{1, 16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, 1'b0, 1'b1, 4};
        vecs[12] = '{2, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b1, 4};
        vecs[13] = '{2, 16'h0010, 16'h0020, 1'b1, 16'h00F0, 1'b0, 1'b0, 4};

        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        sub_in = 1'b0;
        a_in   = '0;
        b_in   = '0;
        repeat (3) @(negedge clk);
        check("reset busy",     {31'd0, busy0}, 32'd0);
        check("reset done",     {31'd0, done0}, 32'd0);
        check("reset result",   {16'd0, res0},  32'd0);
        check("reset cout",     {31'd0, cout0}, 32'd0);
        check("reset overflow", {31'd0, ovf0},  32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors across all three configurations.
        for (int i = 0; i < 14; i++) begin
            launch(vecs[i].dut, vecs[i].a, vecs[i].b, vecs[i].s);
            wait_done(vecs[i].dut, 0, lat, busy_n);
            check($sformatf("vec%0d result", i), {16'd0, get_res(vecs[i].dut)},
                  {16'd0, vecs[i].r});
            check($sformatf("vec%0d cout", i), {31'd0, get_cout(vecs[i].dut)},
                  {31'd0, vecs[i].c});
            check($sformatf("vec%0d overflow", i), {31'd0, get_ovf(vecs[i].dut)},
                  {31'd0, vecs[i].v});
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d busy cycles", i), busy_n, vecs[i].lat);
            @(negedge clk);
        end

        // Start pulse mid-run with other operands must be ignored.
        launch(0, 16'h1111, 16'h2222, 1'b0);
        wait_done(0, 5, lat, busy_n);
        check("glitch result",  {16'd0, res0}, 32'h3333);
        check("glitch latency", lat, 16);
        @(negedge clk);
        check("glitch not queued busy", {31'd0, busy0}, 32'd0);
        check("glitch not queued done", {31'd0, done0}, 32'd0);

        // Start asserted in the done cycle begins the next operation.
        launch(0, 16'h4321, 16'h1234, 1'b1);
        wait_done(0, 0, lat, busy_n);
        check("chain1 result",  {16'd0, res0}, 32'h30ED);
        check("chain1 cout",    {31'd0, cout0}, 32'd1);
        check("chain1 latency", lat, 16);
        launch(0, 16'h8001, 16'h8001, 1'b0);
        check("chain2 accepted busy", {31'd0, busy0}, 32'd1);
        check("chain2 result held",   {16'd0, res0}, 32'h30ED);
        wait_done(0, 0, lat, busy_n);
        check("chain2 result",   {16'd0, res0}, 32'h0002);
        check("chain2 cout",     {31'd0, cout0}, 32'd1);
        check("chain2 overflow", {31'd0, ovf0}, 32'd1);
        check("chain2 latency",  lat, 16);
        @(negedge clk);

        // Reset at cycle 8 of a run aborts with no completion.
        launch(0, 16'h00FF, 16'h0F0F, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy",     {31'd0, busy0}, 32'd0);
        check("abort done",     {31'd0, done0}, 32'd0);
        check("abort result",   {16'd0, res0},  32'd0);
        check("abort cout",     {31'd0, cout0}, 32'd0);
        check("abort overflow", {31'd0, ovf0},  32'd0);
        n_done = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (done0) n_done++;
        end
        check("abort no done pulse", n_done, 0);
        launch(0, 16'h00FF, 16'h0F0F, 1'b0);
        wait_done(0, 0, lat, busy_n);
        check("post-abort result",  {16'd0, res0}, 32'h100E);
        check("post-abort latency", lat, 16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised digit-serial adder/subtractor, successor to the fixed 16-bit, 1-bit-per-cycle serial adder.
- Latches two WIDTH-bit operands on a start handshake.
- Processes DIGIT bits per clock through a ripple digit slice with a registered inter-digit carry.
- Returns result, carry-out and signed overflow with a one-cycle done pulse.
- Sits in the arithmetic datapath wherever area matters more than latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be >= 2.
DIGIT, 1, bits processed per cycle; must divide WIDTH exactly (elaboration-time assertion).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only while busy=0
sub  input  1  mode, sampled with start: 0 = A+B, 1 = A-B
data_a  input  WIDTH  operand A, sampled with start
data_b  input  WIDTH  operand B, sampled with start
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; result/cout/overflow valid
result  output  WIDTH  sum/difference, held until next completion
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset: synchronous, active-high, one clock and one reset only. On any clk edge with reset=1:
  - state=IDLE, busy=0, done=0, result=0, cout=0, overflow=0.
  - Internal counter, carry and shift registers are cleared.
  - Reset mid-operation aborts; no done is issued.
- FSM states: IDLE, RUN.
- IDLE with start=1 at an edge:
  - Latch data_a into shift register A.
  - Latch data_b into shift register B, or ~data_b when sub=1.
  - Carry register = sub.
  - Digit counter = 0; go to RUN; busy=1 from the next cycle.
- IDLE with start=0: hold all state. done is forced to 0 after its pulse cycle.
- RUN, each edge:
  - Add low DIGIT bits of A and B plus the carry register.
  - Shift A and B right by DIGIT.
  - Shift the DIGIT sum bits into the MSB end of the accumulator (LSB-first assembly).
  - Carry register = digit carry-out; counter increments.
- Last digit (counter = WIDTH/DIGIT-1) at an edge:
  - result = final accumulator.
  - cout = final carry.
  - overflow = carry into MSB XOR carry out of MSB.
  - done=1, busy=0, state=IDLE.
- Latency: done is high exactly WIDTH/DIGIT cycles after the edge that accepted start.
  - Defaults: 16 cycles.
  - WIDTH=16, DIGIT=4: 4 cycles.
- start while busy=1: ignored, no queueing; operands are not re-sampled.
- start in the done cycle: accepted (state is IDLE). Next op begins; result stays stable until its own completion.
- data_a/data_b/sub may change freely after acceptance without effect.
- Arithmetic is modulo 2^WIDTH:
  - Add: cout = unsigned carry.
  - Sub: cout = NOT borrow.
- Accumulator width = WIDTH. Counter width = $clog2(WIDTH/DIGIT), minimum 1.

Decomposition:
- Shared package serial_arith_pkg:
  - state enum (IDLE, RUN).
  - Helper function for counter width.
  - Common localparam checks.
- Sub-module serial_digit_adder:
  - Combinational DIGIT-bit ripple adder.
  - Inputs a, b, cin. Outputs sum, cout, and carry into its MSB (for overflow).
  - Instantiated once.
- Top level holds the FSM, shift registers, accumulator and carry register.

Test Plan:
1. WIDTH=16, DIGIT=1: start with A=0x1234, B=0x0FED, sub=0 -> done 16 cycles later; result=0x2221, cout=0, overflow=0; busy high exactly 16 cycles.
2. A=0xFFFF, B=0x0001 add -> result=0x0000, cout=1, overflow=0. Then A=0x7FFF, B=0x0001 -> result=0x8000, cout=0, overflow=1.
3. sub=1, A=0x0005, B=0x0007 -> result=0xFFFE, cout=0 (borrow), overflow=0. Then A=0x8000, B=0x0001 -> result=0x7FFF, cout=1, overflow=1.
4. WIDTH=16, DIGIT=4, A=0xABCD, B=0x1111 add -> done after 4 cycles, result=0xBCDE, cout=0. Repeat for WIDTH=8, DIGIT=2: 0x80+0x80 -> 0x00, cout=1, overflow=1, latency 4.
5. Pulse start again at cycle 5 of a run with different operands -> ignored; first result unchanged. Start asserted in the done cycle -> second op accepted; its done arrives 16 cycles later.
6. Assert reset at cycle 8 of a run -> next cycle busy=0, done=0, result=0, cout=0, overflow=0; no done pulse follows. A fresh start afterwards completes correctly.
